// File: rtl/bl_wl_bank_programmer.sv
// bl_wl_bank_programmer
//   Memory-bank configuration controller for a grid tile's bl/wl bus.
//   On start, programs WL_WIDTH rows. Each row word is shifted in serially
//   over a valid/ready handshake, with the first bit landing in word[0].
//   The word is then driven on bl for one setup cycle. Next, wl[row] is
//   pulsed for WL_PULSE cycles, followed by one hold cycle before the
//   next row begins.
//
//   Ports:
//     prog_clk      programming clock (rising edge)
//     prog_reset_n  asynchronous active-low reset
//     start         request to program all rows (ignored while busy)
//     cfg_data      serial config bit
//     cfg_valid     cfg_data valid
//     cfg_ready     bit accepted this cycle when cfg_valid is high
//     bl            bit-line drive [0:BL_WIDTH-1]
//     wl            word-line drive [0:WL_WIDTH-1], one-hot or zero
//     busy          sequence in progress
//     done          sticky completion flag, cleared by the next start
//     err           sticky parity error flag
//
//   Optional feature macro: BL_WL_BANK_PROGRAMMER_PARITY_EN
//     When defined, each row carries one extra even-parity bit. A row
//     with bad parity loads bl but skips its wl pulse, and err is set.
//     When undefined, no parity bit is consumed and err stays 0.
module bl_wl_bank_programmer #(
  parameter int unsigned BL_WIDTH = 3,
  parameter int unsigned WL_WIDTH = 3,
  parameter int unsigned WL_PULSE = 2
) (
  input  logic                prog_clk,
  input  logic                prog_reset_n,
  input  logic                start,
  input  logic                cfg_data,
  input  logic                cfg_valid,
  output logic                cfg_ready,
  output logic [0:BL_WIDTH-1] bl,
  output logic [0:WL_WIDTH-1] wl,
  output logic                busy,
  output logic                done,
  output logic                err
);

`ifdef BL_WL_BANK_PROGRAMMER_PARITY_EN
  localparam int unsigned NBITS = BL_WIDTH + 1;
`else
  localparam int unsigned NBITS = BL_WIDTH;
`endif
  localparam int unsigned ROW_W = (WL_WIDTH > 1) ? $clog2(WL_WIDTH) : 1;
  localparam int unsigned BIT_W = ($clog2(BL_WIDTH + 1) > 1) ? $clog2(BL_WIDTH + 1) : 1;
  localparam int unsigned PC_W  = (WL_PULSE > 1) ? $clog2(WL_PULSE) : 1;

  typedef enum logic [2:0] {
    IDLE,
    SHIFT,
    SETUP,
    PULSE,
    HOLD,
    DONE
  } state_t;

  state_t             state_q, state_d;
  logic [ROW_W-1:0]   row_q, row_d;
  logic [BIT_W-1:0]   bitcnt_q, bitcnt_d;
  logic [PC_W-1:0]    pcnt_q, pcnt_d;
  logic [0:NBITS-1]   word_q, word_d, word_nxt;
  logic [0:BL_WIDTH-1] bl_q, bl_d;
  logic [0:WL_WIDTH-1] wl_q, wl_d;
  logic               done_q, done_d;
  logic               err_q, err_d;
  logic               perr_q, perr_d;
  logic               par_bad;

  // Word as it would look with the current cfg_data written in.
  always_comb begin
    word_nxt           = word_q;
    word_nxt[bitcnt_q] = cfg_data;
  end

`ifdef BL_WL_BANK_PROGRAMMER_PARITY_EN
  assign par_bad = ^word_nxt;
`else
  assign par_bad = 1'b0;
`endif

  assign cfg_ready = (state_q == SHIFT);
  assign busy      = (state_q != IDLE) && (state_q != DONE);
  assign bl        = bl_q;
  assign wl        = wl_q;
  assign done      = done_q;
  assign err       = err_q;

  always_comb begin
    state_d  = state_q;
    row_d    = row_q;
    bitcnt_d = bitcnt_q;
    pcnt_d   = pcnt_q;
    word_d   = word_q;
    bl_d     = bl_q;
    wl_d     = wl_q;
    done_d   = done_q;
    err_d    = err_q;
    perr_d   = perr_q;
    unique case (state_q)
      IDLE, DONE: begin
        if (start) begin
          row_d    = '0;
          bitcnt_d = '0;
          done_d   = 1'b0;
          err_d    = 1'b0;
          state_d  = SHIFT;
        end
      end
      SHIFT: begin
        if (cfg_valid) begin
          word_d = word_nxt;
          if (bitcnt_q == BIT_W'(NBITS - 1)) begin
            // bl is loaded on the same edge as the last bit, so it is
            // already valid during the SETUP cycle.
            bitcnt_d = '0;
            bl_d     = word_nxt[0:BL_WIDTH-1];
            perr_d   = par_bad;
            err_d    = err_q | par_bad;
            state_d  = SETUP;
          end else begin
            bitcnt_d = bitcnt_q + BIT_W'(1);
          end
        end
      end
      SETUP: begin
        pcnt_d = '0;
        if (perr_q) begin
          state_d = HOLD;
        end else begin
          wl_d        = '0;
          wl_d[row_q] = 1'b1;
          state_d     = PULSE;
        end
      end
      PULSE: begin
        if (pcnt_q == PC_W'(WL_PULSE - 1)) begin
          wl_d    = '0;
          state_d = HOLD;
        end else begin
          pcnt_d = pcnt_q + PC_W'(1);
        end
      end
      HOLD: begin
        if (row_q == ROW_W'(WL_WIDTH - 1)) begin
          bl_d    = '0;
          done_d  = 1'b1;
          state_d = DONE;
        end else begin
          row_d   = row_q + ROW_W'(1);
          state_d = SHIFT;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge prog_clk or negedge prog_reset_n) begin
    if (!prog_reset_n) begin
      state_q  <= IDLE;
      row_q    <= '0;
      bitcnt_q <= '0;
      pcnt_q   <= '0;
      word_q   <= '0;
      bl_q     <= '0;
      wl_q     <= '0;
      done_q   <= 1'b0;
      err_q    <= 1'b0;
      perr_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      row_q    <= row_d;
      bitcnt_q <= bitcnt_d;
      pcnt_q   <= pcnt_d;
      word_q   <= word_d;
      bl_q     <= bl_d;
      wl_q     <= wl_d;
      done_q   <= done_d;
      err_q    <= err_d;
      perr_q   <= perr_d;
    end
  end

endmodule

// File: tb/tb_bl_wl_bank_programmer.sv
// tb_bl_wl_bank_programmer
//   Directed bench for bl_wl_bank_programmer with the default parameters
//   (3 bit lines, 3 word lines, 2-cycle pulse). Row streams carry an even
//   parity bit in position 3, which is consumed only when
//   BL_WL_BANK_PROGRAMMER_PARITY_EN is defined.
module tb_bl_wl_bank_programmer;

`ifdef BL_WL_BANK_PROGRAMMER_PARITY_EN
  localparam int NB = 4;
`else
  localparam int NB = 3;
`endif

  logic       prog_clk;
  logic       prog_reset_n;
  logic       start;
  logic       cfg_data;
  logic       cfg_valid;
  logic       cfg_ready;
  logic [0:2] bl;
  logic [0:2] wl;
  logic       busy;
  logic       done;
  logic       err;

  int checks   = 0;
  int failures = 0;

  logic [0:3] rows [3];

  bl_wl_bank_programmer #(
    .BL_WIDTH(3),
    .WL_WIDTH(3),
    .WL_PULSE(2)
  ) dut (
    .prog_clk    (prog_clk),
    .prog_reset_n(prog_reset_n),
    .start       (start),
    .cfg_data    (cfg_data),
    .cfg_valid   (cfg_valid),
    .cfg_ready   (cfg_ready),
    .bl          (bl),
    .wl          (wl),
    .busy        (busy),
    .done        (done),
    .err         (err)
  );

  initial prog_clk = 1'b0;
  always #5 prog_clk = ~prog_clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge prog_clk);
    #1;
  endtask

  task automatic chk_all_zero(input string tag);
    chk(tag, {26'd0, cfg_ready, busy, done, err, bl, wl}, 32'd0);
  endtask

  // One row: shift bits, then check SETUP / PULSE / HOLD. When is_last is
  // set, the task returns in the HOLD cycle with start still at 'spam'.
  task automatic run_row(input logic [0:3] bits, input int row, input bit gaps,
                         input bit spam, input bit pulse_ok, input bit abort,
                         input bit is_last);
    logic [0:2] eb;
    logic [0:2] ew;
    eb      = bits[0:2];
    ew      = '0;
    ew[row] = 1'b1;
    for (int i = 0; i < NB; i++) begin
      if (gaps) begin
        cfg_valid = 1'b0;
        cfg_data  = ~bits[i];
        repeat ($urandom_range(0, 2)) begin
          tick();
          chk("stall_ready", cfg_ready, 1);
          chk("stall_wl", wl, 0);
        end
      end
      cfg_valid = 1'b1;
      cfg_data  = bits[i];
      start     = spam;
      tick();
    end
    // cfg_valid stays high outside SHIFT; no bit may be consumed.
    cfg_data = 1'b1;
    chk("setup_ready", cfg_ready, 0);
    chk("setup_bl", bl, eb);
    chk("setup_wl", wl, 0);
    if (pulse_ok) begin
      tick();
      chk("pulse1_wl", wl, ew);
      chk("pulse1_bl", bl, eb);
      if (abort) return;
      tick();
      chk("pulse2_wl", wl, ew);
      chk("pulse2_bl", bl, eb);
    end
    tick();
    chk("hold_wl", wl, 0);
    chk("hold_bl", bl, eb);
    chk("hold_busy", busy, 1);
    if (!is_last) begin
      tick();
      chk("next_ready", cfg_ready, 1);
      start = 1'b0;
    end
  endtask

  task automatic do_start();
    start     = 1'b1;
    cfg_valid = 1'b0;
    tick();
    start = 1'b0;
    chk("start_busy", busy, 1);
    chk("start_done", done, 0);
    chk("start_err", err, 0);
    chk("start_ready", cfg_ready, 1);
  endtask

  task automatic finish_seq(input bit spam);
    // In the last HOLD cycle; start may be high and must be ignored.
    chk("pre_done", done, 0);
    tick();
    start = 1'b0;
    chk("done_flag", done, 1);
    chk("done_busy", busy, 0);
    chk("done_bl", bl, 0);
    chk("done_wl", wl, 0);
    tick();
    chk("done_stay", done, 1);
    chk("done_stay_busy", busy, spam ? 0 : 0);
    cfg_valid = 1'b0;
  endtask

  task automatic run_full(input bit gaps, input bit spam);
    do_start();
    run_row(rows[0], 0, gaps, spam, 1'b1, 1'b0, 1'b0);
    run_row(rows[1], 1, gaps, spam, 1'b1, 1'b0, 1'b0);
    run_row(rows[2], 2, gaps, spam, 1'b1, 1'b0, 1'b1);
    finish_seq(spam);
  endtask

  initial begin
    rows[0] = 4'b1010;
    rows[1] = 4'b0110;
    rows[2] = 4'b1100;

    // Reset with random inputs
    prog_reset_n = 1'b0;
    start        = 1'b0;
    cfg_valid    = 1'b0;
    cfg_data     = 1'b0;
    #1;
    chk_all_zero("reset_t0");
    repeat (4) begin
      start     = 1'($urandom);
      cfg_valid = 1'($urandom);
      cfg_data  = 1'($urandom);
      tick();
      chk_all_zero("reset_rand");
    end
    start        = 1'b0;
    cfg_valid    = 1'b0;
    prog_reset_n = 1'b1;
    tick();
    chk_all_zero("idle_after_reset");

    // Full program, cfg_valid held high, done on cycle 21
    run_full(1'b0, 1'b0);

    // start pulses throughout, including the last HOLD cycle
    run_full(1'b0, 1'b1);

    // Random cfg_valid gaps
    run_full(1'b1, 1'b0);

    // Reset during the wl[1] pulse
    do_start();
    run_row(rows[0], 0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    run_row(rows[1], 1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
    #2;
    prog_reset_n = 1'b0;
    #1;
    chk_all_zero("midpulse_reset");
    cfg_valid = 1'b0;
    tick();
    prog_reset_n = 1'b1;
    tick();
    tick();
    chk("no_autorestart_busy", busy, 0);
    chk("no_autorestart_ready", cfg_ready, 0);
    run_full(1'b1, 1'b0);

`ifdef BL_WL_BANK_PROGRAMMER_PARITY_EN
    // Row 1 with bad parity: no wl[1] pulse, err sticky, sequence completes
    do_start();
    run_row(4'b1010, 0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    chk("par_err_row0", err, 0);
    run_row(4'b0111, 1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("par_err_row1", err, 1);
    run_row(4'b1100, 2, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1);
    finish_seq(1'b0);
    chk("par_err_final", err, 1);
    do_start();
    chk("par_err_cleared", err, 0);
`else
    chk("err_tied", err, 0);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
